regfile_wb_arbiter: RTL

- Producer side of the register-file write port. Merges two write sources into the single `we/wa/wd` port of `regfile`:
  - the in-order pipeline writeback;
  - completions from long-latency units (multiply/divide, load-miss return).
- Long-latency results are buffered in an ordered queue and drained when the pipeline does not need the port.
- Outputs per-register pending flags so decode can stall on registers whose write has not yet committed.

---
 rtl/regfile_wb_arbiter_pkg.sv | 14 +
 rtl/wb_queue.sv | 92 +++++++++
 rtl/regfile_wb_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter: source-select
// encodings and default geometry.
package regfile_wb_arbiter_pkg;

    localparam logic [1:0] SRC_NONE  = 2'd0;
    localparam logic [1:0] SRC_PIPE  = 2'd1;
    localparam logic [1:0] SRC_QUEUE = 2'd2;

    localparam int DEF_DEPTH      = 4;
    localparam int DEF_AW         = 5;
    localparam int DEF_DW         = 32;
    localparam int DEF_STARVE_MAX = 8;

endpackage

// File: rtl/wb_queue.sv
// Ordered completion queue for long-latency results: circular buffer with
// per-entry valid/live bits, address kill and two read-address match ports.
module wb_queue
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [AW-1:0] push_wa,
    input  logic [DW-1:0] push_wd,
    input  logic          pop,
    input  logic          kill,
    input  logic [AW-1:0] kill_addr,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [AW-1:0] head_wa,
    output logic [DW-1:0] head_wd,
    output logic          head_live,
    output logic [CW-1:0] count,
    output logic          match1,
    output logic          match2
);

    logic [AW-1:0]    wa_mem [DEPTH];
    logic [DW-1:0]    wd_mem [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] live_q;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            wa_mem[wr_ptr] <= push_wa;
            wd_mem[wr_ptr] <= push_wd;
        end
    end

    // Kill is applied first so a same-cycle push of the killed address
    // lands already dead; pop and push never target the same slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            live_q  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && valid_q[i] && wa_mem[i] == kill_addr)
                    live_q[i] <= 1'b0;
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                live_q[rd_ptr]  <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                live_q[wr_ptr]  <= !(kill && kill_addr == push_wa);
                wr_ptr          <= wr_ptr + 1'b1;
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && live_q[i] && wa_mem[i] == ra1) match1 = 1'b1;
            if (valid_q[i] && live_q[i] && wa_mem[i] == ra2) match2 = 1'b1;
        end
    end

    assign head_wa   = wa_mem[rd_ptr];
    assign head_wd   = wd_mem[rd_ptr];
    assign head_live = live_q[rd_ptr];
    assign count     = count_q;

    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        !(pop && count_q == '0));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && !pop && count_q == CW'(DEPTH)));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges pipeline writeback and queued long-latency results onto the regfile
// write port. Optional starvation guard: define WB_STARVE_GUARD_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX,
    localparam int CW        = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_wa,
    input  logic [DW-1:0] pipe_wd,
    input  logic          lu_valid,
    output logic          lu_ready,
    input  logic [AW-1:0] lu_wa,
    input  logic [DW-1:0] lu_wd,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          pend1,
    output logic          pend2,
    output logic          pipe_stall,
    output logic [CW-1:0] count
);

    // Handshake: a result is accepted on a rising edge where lu_valid && lu_ready;
    // lu_ready depends only on registered count, never on this cycle's pop.
    logic          pipe_eff;
    logic          push;
    logic          pop;
    logic          force_pop;
    logic [1:0]    sel;
    logic [AW-1:0] head_wa;
    logic [DW-1:0] head_wd;
    logic          head_live;
    logic          match1;
    logic          match2;

    assign pipe_eff = pipe_we && (pipe_wa != '0);
    assign lu_ready = (count != CW'(DEPTH));
    assign push     = lu_valid && lu_ready && (lu_wa != '0);

`ifdef WB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            starve_cnt <= '0;
        else if (pop || count == '0)
            starve_cnt <= '0;
        else if (pipe_eff && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

    assign force_pop  = (starve_cnt == SW'(STARVE_MAX)) && (count != '0);
    assign pipe_stall = force_pop;

    a_stall_honoured: assert property (@(posedge clk) disable iff (!reset)
        !(pipe_stall && pipe_eff));
`else
    logic unused_starve_cfg;
    assign unused_starve_cfg = STARVE_MAX[0];
    assign force_pop  = 1'b0;
    assign pipe_stall = 1'b0;
`endif

    always_comb begin
        sel = SRC_NONE;
        if (force_pop)
            sel = SRC_QUEUE;
        else if (pipe_eff)
            sel = SRC_PIPE;
        else if (count != '0)
            sel = SRC_QUEUE;
    end

    assign pop = (sel == SRC_QUEUE);

    wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_wa   (lu_wa),
        .push_wd   (lu_wd),
        .pop       (pop),
        .kill      (sel == SRC_PIPE),
        .kill_addr (pipe_wa),
        .ra1       (ra1),
        .ra2       (ra2),
        .head_wa   (head_wa),
        .head_wd   (head_wd),
        .head_live (head_live),
        .count     (count),
        .match1    (match1),
        .match2    (match2)
    );

    // A popped entry that was killed frees its slot but writes nothing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else begin
            case (sel)
                SRC_PIPE: begin
                    rf_we <= 1'b1;
                    rf_wa <= pipe_wa;
                    rf_wd <= pipe_wd;
                end
                SRC_QUEUE: begin
                    rf_we <= head_live;
                    rf_wa <= head_wa;
                    rf_wd <= head_wd;
                end
                default: rf_we <= 1'b0;
            endcase
        end
    end

    assign pend1 = (ra1 != '0) && (match1 || (rf_we && rf_wa == ra1));
    assign pend2 = (ra2 != '0) && (match2 || (rf_we && rf_wa == ra2));

endmodule
